sseg_scan_driver: RTL and testbench

Parameterised, time-multiplexed driver for an N-digit seven-segment display. It takes over from the single-digit BCD-to-segment conversion by adding a hex/BCD mode, leading-zero suppression, per-digit decimal points, anode scanning with an anti-ghosting guard interval, and tear-free value updates applied only at frame boundaries. It sits between the datapath that produces a display value and the board's segment and anode pins.

---
 rtl/sseg_scan_driver.sv | 111 +++++++++++
 tb/tb_sseg_scan_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed N-digit seven-segment driver with frame-synchronous value updates
module sseg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 1,
  parameter int COMMON_ANODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  output logic [6:0]            sseg,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an,
  output logic                  pending,
  output logic                  frame_tick
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic INV = COMMON_ANODE != 0;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*N_DIGITS-1:0] stage_val_q, stage_val_d, shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0] stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic pending_q, pending_d, tick_q, tick_d;
  logic [6:0] sseg_q, sseg_d;
  logic dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic slot_end, boundary, guard, blank;
  logic [3:0] nib;
  logic [6:0] glyph;
  always_comb begin
    slot_end = cnt_q == CNT_MAX;
    boundary = slot_end && idx_q == IDX_MAX;
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? (idx_q == IDX_MAX ? '0 : idx_q + 1'b1) : idx_q;
    stage_val_d = load ? value : stage_val_q;
    stage_dp_d = load ? dp : stage_dp_q;
    shadow_val_d = boundary ? (load ? value : stage_val_q) : shadow_val_q;
    shadow_dp_d = boundary ? (load ? dp : stage_dp_q) : shadow_dp_q;
    pending_d = !boundary && (load || pending_q);
    tick_d = boundary;
  end
  always_comb begin
    nib = shadow_val_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
  always_comb begin
    guard = cnt_q < GUARD_C;
    // shifting out the lower digits leaves zero only when this digit and all above it are zero
    blank = lz_blank && idx_q != '0 && (shadow_val_q >> {idx_q, 2'b00}) == '0;
    an_d = (guard ? '0 : N_DIGITS'(1) << idx_q) ^ {N_DIGITS{INV}};
    sseg_d = (guard || blank ? 7'h00 : !hex_mode && nib > 4'd9 ? 7'h40 : glyph) ^ {7{INV}};
    dp_d = (!guard && shadow_dp_q[idx_q]) ^ INV;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      stage_val_q <= '0;
      stage_dp_q <= '0;
      shadow_val_q <= '0;
      shadow_dp_q <= '0;
      pending_q <= 1'b0;
      tick_q <= 1'b0;
      an_q <= {N_DIGITS{INV}};
      sseg_q <= {7{INV}};
      dp_q <= INV;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      stage_val_q <= stage_val_d;
      stage_dp_q <= stage_dp_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q <= pending_d;
      tick_q <= tick_d;
      an_q <= an_d;
      sseg_q <= sseg_d;
      dp_q <= dp_d;
    end
  end
  assign sseg = sseg_q;
  assign dp_out = dp_q;
  assign an = an_q;
  assign pending = pending_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: time-indexed reference model checked every cycle, plus directed literal checks
module tb_sseg_scan_driver;
  localparam int N = 4, R = 4, G = 1;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, hex_mode = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp = '0;
  logic [6:0] sseg;
  logic dp_out, pending, frame_tick;
  logic [3:0] an;
  int errors = 0, checks = 0;

  sseg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(R), .GUARD(G), .COMMON_ANODE(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .hex_mode(hex_mode),
    .lz_blank(lz_blank), .sseg(sseg), .dp_out(dp_out), .an(an), .pending(pending),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] glyph_of(logic [15:0] v, int d, logic hex, logic lz);
    logic [3:0] n;
    bit lead;
    n = v[4*d +: 4];
    lead = d > 0;
    for (int k = d; k < N; k++) if (v[4*k +: 4] != 4'h0) lead = 0;
    if (lz && lead) return 7'h00;
    if (!hex && n > 4'd9) return 7'h40;
    return SEG[n];
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // model state: m_t is cycles since reset; slot and digit follow from it by arithmetic
  int m_t = 0, pos, dig;
  logic bnd, m_ok = 1'b0, m_pend = 1'b0;
  logic [15:0] m_stage = '0, m_shadow = '0;
  logic [3:0] m_dstage = '0, m_sdp = '0, e_an;
  logic [6:0] e_seg;
  logic e_dp, e_tick;

  always_comb begin
    pos = m_t % R;
    dig = (m_t / R) % N;
    bnd = pos == R - 1 && dig == N - 1;
  end

  always @(posedge clk) begin
    m_ok <= 1'b1;
    if (rst) begin
      m_t <= 0;
      m_stage <= '0;
      m_dstage <= '0;
      m_shadow <= '0;
      m_sdp <= '0;
      m_pend <= 1'b0;
      e_an <= 4'hF;
      e_seg <= 7'h7F;
      e_dp <= 1'b1;
      e_tick <= 1'b0;
    end else begin
      e_an <= (pos < G) ? 4'hF : ~(4'b0001 << dig);
      e_seg <= (pos < G) ? 7'h7F : ~glyph_of(m_shadow, dig, hex_mode, lz_blank);
      e_dp <= (pos < G) ? 1'b1 : ~m_sdp[dig];
      e_tick <= bnd;
      m_t <= m_t + 1;
      if (load) begin
        m_stage <= value;
        m_dstage <= dp;
      end
      if (bnd) begin
        m_shadow <= load ? value : m_stage;
        m_sdp <= load ? dp : m_dstage;
        m_pend <= 1'b0;
      end else if (load) m_pend <= 1'b1;
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("an", 16'(an), 16'(e_an));
    chk("sseg", 16'(sseg), 16'(e_seg));
    chk("dp_out", 16'(dp_out), 16'(e_dp));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("frame_tick", 16'(frame_tick), 16'(e_tick));
  end

  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("tick_timeout", 16'(n), 16'd0);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic see(input string name, input int d, input logic [6:0] s, input logic p);
    logic [3:0] tgt;
    int n = 0;
    tgt = ~(4'b0001 << d);
    while (an !== tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({name, "_timeout"}, 16'(n), 16'd0);
    else begin
      chk({name, "_sseg"}, 16'(sseg), 16'(s));
      chk({name, "_dp"}, 16'(dp_out), 16'(p));
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_sseg", 16'(sseg), 16'h007F);
    chk("rst_pending", 16'(pending), 16'h0000);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    chk("first_tick", 16'(n), 16'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    chk("tick_period", 16'(n), 16'd16);

    load_val(16'h1234, 4'b0100);
    wait_tick();
    see("bcd_d0", 0, ~7'h66, 1'b1);
    see("bcd_d1", 1, ~7'h4F, 1'b1);
    see("bcd_d2", 2, ~7'h5B, 1'b0);
    see("bcd_d3", 3, ~7'h06, 1'b1);

    hex_mode = 1'b1;
    load_val(16'h00AF, 4'b0000);
    wait_tick();
    see("hex_d0", 0, ~7'h71, 1'b1);
    see("hex_d1", 1, ~7'h77, 1'b1);
    hex_mode = 1'b0;
    wait_tick();
    see("dash_d0", 0, ~7'h40, 1'b1);
    see("dash_d1", 1, ~7'h40, 1'b1);

    lz_blank = 1'b1;
    load_val(16'h0050, 4'b0000);
    wait_tick();
    see("lz_d0", 0, ~7'h3F, 1'b1);
    see("lz_d1", 1, ~7'h6D, 1'b1);
    see("lz_d2", 2, 7'h7F, 1'b1);
    see("lz_d3", 3, 7'h7F, 1'b1);
    load_val(16'h0000, 4'b0000);
    wait_tick();
    see("zero_d0", 0, ~7'h3F, 1'b1);
    see("zero_d1", 1, 7'h7F, 1'b1);
    see("zero_d2", 2, 7'h7F, 1'b1);
    see("zero_d3", 3, 7'h7F, 1'b1);

    lz_blank = 1'b0;
    wait_tick();
    repeat (4) @(negedge clk);
    load_val(16'h1111, 4'b0000);
    @(negedge clk);
    load_val(16'h2222, 4'b0000);
    chk("tear_pending", 16'(pending), 16'h0001);
    see("tear_old_d3", 3, ~7'h3F, 1'b1);
    chk("tear_pending_d3", 16'(pending), 16'h0001);
    wait_tick();
    chk("tear_pending_clr", 16'(pending), 16'h0000);
    see("tear_d0", 0, ~7'h5B, 1'b1);
    see("tear_d1", 1, ~7'h5B, 1'b1);
    see("tear_d2", 2, ~7'h5B, 1'b1);
    see("tear_d3", 3, ~7'h5B, 1'b1);

    wait_tick();
    repeat (15) @(negedge clk);
    load_val(16'h3333, 4'b0000);
    chk("bnd_tick", 16'(frame_tick), 16'h0001);
    chk("bnd_pending", 16'(pending), 16'h0000);
    see("bnd_d0", 0, ~7'h4F, 1'b1);
    see("bnd_d3", 3, ~7'h4F, 1'b1);

    wait_tick();
    see("pre_rst_d0", 0, ~7'h4F, 1'b1);
    load_val(16'h9876, 4'b1111);
    see("pre_rst_d2", 2, ~7'h4F, 1'b1);
    chk("pre_rst_pending", 16'(pending), 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_an", 16'(an), 16'h000F);
    chk("mid_rst_sseg", 16'(sseg), 16'h007F);
    chk("mid_rst_pending", 16'(pending), 16'h0000);
    @(negedge clk);
    chk("restart_guard_an", 16'(an), 16'h000F);
    @(negedge clk);
    chk("restart_d0_an", 16'(an), 16'h000E);
    wait_tick();
    see("clr_d0", 0, ~7'h3F, 1'b1);
    see("clr_d1", 1, ~7'h3F, 1'b1);
    see("clr_d2", 2, ~7'h3F, 1'b1);
    see("clr_d3", 3, ~7'h3F, 1'b1);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load = $urandom_range(0, 7) == 0;
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'h00FF : 16'($urandom);
      dp = 4'($urandom);
      if ($urandom_range(0, 29) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
      rst = $urandom_range(0, 149) == 0;
    end
    @(negedge clk);
    load = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
